// File: rtl/rv_pkg.sv
// Shared register-file constants and the writeback entry format
// used by the controller and its long-latency result buffer.
package rv_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency writeback entries until the
// register file write port is free.
module wb_fifo
   import rv_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t wdata,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int AW = $clog2(FIFO_DEPTH);

   wb_entry_t       mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;

   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU and buffered long-latency results onto the
// single register-file write port and tracks outstanding long writes for hazards.
module wb_ctrl
   import rv_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_iss_valid,
   input  logic        i_iss_long,
   input  logic [4:0]  i_iss_rd,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   input  logic        i_alu_valid,
   input  logic [4:0]  i_alu_rd,
   input  logic [31:0] i_alu_data,
   input  logic        i_lsu_valid,
   input  logic [4:0]  i_lsu_rd,
   input  logic [31:0] i_lsu_data,
   output logic        o_lsu_ready,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_rd_wren,
   output logic [31:0] o_busy,
   output logic        o_stall
);

   wb_entry_t        lsu_entry;
   wb_entry_t        head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             alu_wr;
   logic             iss_set;
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_next;

   assign lsu_entry   = '{rd: i_lsu_rd, data: i_lsu_data};
   assign o_lsu_ready = !full;
   // x0 results complete the handshake but never occupy a slot.
   assign push        = i_lsu_valid && !full && (i_lsu_rd != '0);
   assign alu_wr      = i_rst && i_alu_valid && (i_alu_rd != '0);
   assign pop         = i_rst && !alu_wr && !empty;

   wb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst),
      .push  (push),
      .pop   (pop),
      .wdata (lsu_entry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_comb begin
      o_rd_wren = 1'b0;
      o_rd_addr = '0;
      o_rd_data = '0;
      if (alu_wr) begin
         o_rd_wren = 1'b1;
         o_rd_addr = i_alu_rd;
         o_rd_data = i_alu_data;
      end else if (pop) begin
         o_rd_wren = 1'b1;
         o_rd_addr = head.rd;
         o_rd_data = head.data;
      end
   end

   // busy[0] is held at zero, so x0 can never raise a hazard.
   assign o_stall = busy[i_rs1_addr] || busy[i_rs2_addr] ||
                    (i_iss_valid && busy[i_iss_rd]);
   assign iss_set = i_iss_valid && i_iss_long && !o_stall && (i_iss_rd != '0);
   assign o_busy  = busy;

   always_comb begin
      busy_next = busy;
      if (pop)     busy_next[head.rd]  = 1'b0;
      if (iss_set) busy_next[i_iss_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) busy <= '0;
      else        busy <= busy_next;
   end

endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: a queue-based reference model predicts every
// cycle's write-port and hazard outputs; a negedge monitor compares them.
module tb_wb_ctrl;

   localparam int FIFO_DEPTH = 4;

   logic        i_clk;
   logic        i_rst;
   logic        i_iss_valid;
   logic        i_iss_long;
   logic [4:0]  i_iss_rd;
   logic [4:0]  i_rs1_addr;
   logic [4:0]  i_rs2_addr;
   logic        i_alu_valid;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data;
   logic        i_lsu_valid;
   logic [4:0]  i_lsu_rd;
   logic [31:0] i_lsu_data;
   logic        o_lsu_ready;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_rd_wren;
   logic [31:0] o_busy;
   logic        o_stall;

   wb_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_iss_valid (i_iss_valid),
      .i_iss_long  (i_iss_long),
      .i_iss_rd    (i_iss_rd),
      .i_rs1_addr  (i_rs1_addr),
      .i_rs2_addr  (i_rs2_addr),
      .i_alu_valid (i_alu_valid),
      .i_alu_rd    (i_alu_rd),
      .i_alu_data  (i_alu_data),
      .i_lsu_valid (i_lsu_valid),
      .i_lsu_rd    (i_lsu_rd),
      .i_lsu_data  (i_lsu_data),
      .o_lsu_ready (o_lsu_ready),
      .o_rd_addr   (o_rd_addr),
      .o_rd_data   (o_rd_data),
      .o_rd_wren   (o_rd_wren),
      .o_busy      (o_busy),
      .o_stall     (o_stall)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        wren;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        ready;
      logic        stall;
      logic [31:0] busy;
   } st_t;

   // Reference model state: pending results in arrival order, outstanding registers.
   wr_t          mq[$];
   logic [31:0]  mbusy;
   logic [4:0]   pend[$];

   // Scoreboard queues filled by the stimulus, drained by the monitor.
   wr_t          wq[$];
   st_t          st_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         chk("rst_wren",  32'(o_rd_wren),   32'd0);
         chk("rst_addr",  32'(o_rd_addr),   32'd0);
         chk("rst_data",  o_rd_data,        32'd0);
         chk("rst_busy",  o_busy,           32'd0);
         chk("rst_stall", 32'(o_stall),     32'd0);
         chk("rst_ready", 32'(o_lsu_ready), 32'd1);
      end else if (st_q.size() > 0) begin
         st_t s;
         s = st_q.pop_front();
         chk("wren",  32'(o_rd_wren),   32'(s.wren));
         chk("ready", 32'(o_lsu_ready), 32'(s.ready));
         chk("stall", 32'(o_stall),     32'(s.stall));
         chk("busy",  o_busy,           s.busy);
         if (!s.wren) begin
            chk("idle_addr", 32'(o_rd_addr), 32'd0);
            chk("idle_data", o_rd_data,      32'd0);
         end
         if (o_rd_wren) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 32'(o_rd_addr), 32'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = wq.pop_front();
               chk("wr_addr", 32'(o_rd_addr), 32'(w.addr));
               chk("wr_data", o_rd_data,      w.data);
            end
         end
      end
   end

   // Predict this cycle's outputs from the model, then advance the model by one edge.
   task automatic step(output bit acc);
      st_t s;
      bit  do_pop;
      wr_t w;
      s.ready = (mq.size() < FIFO_DEPTH);
      s.stall = (i_rs1_addr != 0 && mbusy[i_rs1_addr]) ||
                (i_rs2_addr != 0 && mbusy[i_rs2_addr]) ||
                (i_iss_valid && i_iss_rd != 0 && mbusy[i_iss_rd]);
      s.busy  = mbusy;
      do_pop  = 1'b0;
      if (i_alu_valid && i_alu_rd != 0) begin
         s.wren = 1'b1; s.addr = i_alu_rd; s.data = i_alu_data;
      end else if (mq.size() > 0) begin
         s.wren = 1'b1; s.addr = mq[0].addr; s.data = mq[0].data; do_pop = 1'b1;
      end else begin
         s.wren = 1'b0; s.addr = '0; s.data = '0;
      end
      st_q.push_back(s);
      if (s.wren) wq.push_back('{s.addr, s.data});
      acc = i_lsu_valid && s.ready;
      if (do_pop) begin
         w = mq.pop_front();
         mbusy[w.addr] = 1'b0;
      end
      if (acc && i_lsu_rd != 0) mq.push_back('{i_lsu_rd, i_lsu_data});
      if (i_iss_valid && i_iss_long && !s.stall && i_iss_rd != 0) begin
         mbusy[i_iss_rd] = 1'b1;
         pend.push_back(i_iss_rd);
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_iss_valid = 0; i_iss_long = 0; i_iss_rd = 0;
      i_rs1_addr = 0; i_rs2_addr = 0;
      i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
      i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
   endtask

   task automatic rand_inputs();
      i_iss_valid = 1'($urandom); i_iss_long = 1'($urandom);
      i_iss_rd = 5'($urandom); i_rs1_addr = 5'($urandom); i_rs2_addr = 5'($urandom);
      i_alu_valid = 1'($urandom); i_alu_rd = 5'($urandom); i_alu_data = $urandom;
      i_lsu_valid = 1'($urandom); i_lsu_rd = 5'($urandom); i_lsu_data = $urandom;
   endtask

   task automatic do_reset(input int n);
      if (wq.size() != 0) begin
         chk("writes_outstanding_at_reset", 32'(wq.size()), 32'd0);
         wq.delete();
      end
      i_rst = 1'b0;
      mq.delete(); pend.delete(); mbusy = '0;
      for (int k = 0; k < n; k++) begin
         rand_inputs();
         @(posedge i_clk);
         #1;
      end
      i_rst = 1'b1;
      idle();
   endtask

   initial begin
      bit acc;
      bit hold;
      int tries;
      mbusy = '0;
      idle();
      i_rst = 1'b1;
      #1;
      do_reset(4);

      // Long op to x5, then a reader of x5 stalls until the result lands.
      i_iss_valid = 1; i_iss_long = 1; i_iss_rd = 5;
      step(acc);
      idle(); i_rs1_addr = 5;
      step(acc);
      i_lsu_valid = 1; i_lsu_rd = 5; i_lsu_data = 32'hDEADBEEF;
      step(acc);
      chk("x5_accepted", 32'(acc), 32'd1);
      i_lsu_valid = 0;
      step(acc);
      step(acc);
      pend.delete();

      // ALU priority over a queued result.
      idle();
      i_lsu_valid = 1; i_lsu_rd = 7; i_lsu_data = 32'h11;
      i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'h22;
      step(acc);
      i_lsu_valid = 0;
      step(acc);
      i_alu_valid = 0;
      step(acc);
      step(acc);

      // Fill the FIFO behind a busy ALU, then hold a fifth result until space frees.
      idle();
      i_alu_valid = 1; i_alu_rd = 2; i_alu_data = 32'h5A5A_0002;
      for (int k = 0; k < 4; k++) begin
         i_lsu_valid = 1; i_lsu_rd = 5'(10 + k); i_lsu_data = 32'hC0DE_0000 + k;
         step(acc);
      end
      i_lsu_rd = 14; i_lsu_data = 32'hC0DE_0004;
      step(acc);
      chk("fifth_blocked_when_full", 32'(acc), 32'd0);
      step(acc);
      i_alu_valid = 0;
      tries = 0;
      acc = 0;
      while (!acc && tries < 20) begin
         step(acc);
         tries++;
      end
      chk("fifth_eventually_accepted", 32'(acc), 32'd1);
      idle();
      repeat (8) step(acc);

      // x0 never writes, never sets busy, never stalls.
      i_lsu_valid = 1; i_lsu_rd = 0; i_lsu_data = 32'h1234;
      i_alu_valid = 1; i_alu_rd = 0; i_alu_data = 32'h5678;
      i_iss_valid = 1; i_iss_long = 1; i_iss_rd = 0;
      repeat (3) step(acc);
      idle();
      step(acc);

      // Reset with three entries queued and x5/x6 outstanding.
      i_alu_valid = 1; i_alu_rd = 1; i_alu_data = 32'hAAAA;
      i_iss_valid = 1; i_iss_long = 1; i_iss_rd = 5;
      step(acc);
      i_iss_rd = 6;
      step(acc);
      i_iss_valid = 0;
      for (int k = 0; k < 3; k++) begin
         i_lsu_valid = 1; i_lsu_rd = (k == 2) ? 5'd9 : 5'(5 + k); i_lsu_data = 32'hBAD0 + k;
         step(acc);
      end
      chk("busy_before_reset", o_busy, 32'h0000_0060);
      do_reset(3);
      repeat (10) step(acc);

      // Randomized traffic; the LSU side holds a refused result until accepted.
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) begin
            do_reset(2);
            hold = 0;
         end
         if (!hold) begin
            i_lsu_valid = ($urandom_range(0, 2) == 0);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) i_lsu_rd = pend.pop_front();
            else i_lsu_rd = 5'($urandom_range(0, 7));
            i_lsu_data = $urandom;
         end
         i_alu_valid = 1'($urandom);
         i_alu_rd    = 5'($urandom_range(0, 7));
         i_alu_data  = $urandom;
         i_iss_valid = 1'($urandom);
         i_iss_long  = 1'($urandom);
         i_iss_rd    = 5'($urandom_range(0, 7));
         i_rs1_addr  = 5'($urandom_range(0, 7));
         i_rs2_addr  = 5'($urandom_range(0, 7));
         step(acc);
         hold = i_lsu_valid && !acc;
      end
      idle();
      repeat (10) step(acc);

      chk("writes_outstanding_at_end", 32'(wq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller: the initiator side of the register file write port; the only block driving i_rd_addr / i_rd_data / i_rd_wren into the register file.
- Merges two result sources into the single write port:
  - single-cycle ALU results, high priority;
  - long-latency LSU/divider results, buffered in a small FIFO.
- Keeps a 32-bit scoreboard of registers with outstanding long-latency writes and raises a stall to decode on RAW/WAW hazards.
- Sits between execute/memory and the register file.

Parameters:
- FIFO_DEPTH, 4, entries in the long-latency result buffer; power of two, >= 2.
- NREG, 32, architectural registers (fixed at 32; the parameter exists only for package consistency).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-low reset
- i_iss_valid  in  1  decode issues an instruction this cycle
- i_iss_long  in  1  issued instruction completes via the long-latency port
- i_iss_rd  in  5  destination register of the issued instruction
- i_rs1_addr  in  5  decode source register 1 (hazard check)
- i_rs2_addr  in  5  decode source register 2 (hazard check)
- i_alu_valid  in  1  single-cycle result valid
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_lsu_valid  in  1  long-latency result valid
- i_lsu_rd  in  5  long-latency destination register
- i_lsu_data  in  32  long-latency result
- o_lsu_ready  out  1  FIFO can accept (= !full)
- o_rd_addr  out  5  to regfile i_rd_addr
- o_rd_data  out  32  to regfile i_rd_data
- o_rd_wren  out  1  to regfile i_rd_wren
- o_busy  out  32  scoreboard bitmap; bit 0 always 0
- o_stall  out  1  decode must hold this cycle

Behaviour:
- Reset (i_rst=0, asynchronous):
  - FIFO emptied (rd/wr pointers and count = 0);
  - busy = 0, so o_stall = 0;
  - o_lsu_ready = 1, o_rd_wren = 0, o_rd_addr = 0, o_rd_data = 0.
- Reset mid-operation discards all queued results and busy bits.
- LSU accept: an entry is pushed on the rising edge when i_lsu_valid && o_lsu_ready.
  - If i_lsu_rd == 0, the result is accepted (handshake completes) but not pushed.
  - i_lsu_valid while full: no push. The source must hold the result; it is not lost.
- Write port (combinational, one write per cycle, committed by the regfile at the next rising edge):
  - i_alu_valid && i_alu_rd != 0: drive ALU result, wren = 1.
  - Otherwise, FIFO non-empty: drive head entry, wren = 1, pop at the rising edge.
  - Otherwise: wren = 0, addr = 0, data = 0.
- ALU with rd == 0 does not block the FIFO drain.
- Simultaneous push and pop in the same cycle are both performed; count unchanged.
- Pop from the full state frees a slot, but o_lsu_ready deasserts for that cycle (ready is based on the registered count only, no combinational ready-through-pop).
- Pointers wrap modulo FIFO_DEPTH. Entries are drained in order.
- Scoreboard updates at the rising edge:
  - Set busy[i_iss_rd] when i_iss_valid && i_iss_long && !o_stall && i_iss_rd != 0.
  - Clear busy[addr] when a FIFO pop writes that addr.
  - Same register set and cleared in the same cycle: set wins.
- o_stall (combinational), asserted when any of:
  - busy[i_rs1_addr] (RAW);
  - busy[i_rs2_addr] (RAW);
  - i_iss_valid && busy[i_iss_rd] (WAW).
  - x0 never stalls.
- While a register is being written (busy still 1 that cycle), a reader stalls. It sees the new value in the next cycle, because the regfile has no bypass.
- An ALU write to a busy register cannot occur while the stall is honoured; wb_ctrl does not check for it.

Decomposition:
- Shared package rv_pkg:
  - REG_AW = 5, XLEN = 32, NREG = 32;
  - typedef wb_entry_t = packed struct {rd[4:0], data[31:0]}.
- One natural sub-module: wb_fifo, a synchronous FIFO of wb_entry_t.
  - Parameter FIFO_DEPTH, async active-low reset.
  - Ports: push / pop / full / empty / head.
- Scoreboard and priority mux stay in wb_ctrl.

Test Plan:
- Reset: hold i_rst=0 with all inputs random, then release. Required: o_rd_wren=0, o_busy=0, o_stall=0, o_lsu_ready=1.
- Long op, then RAW hazard:
  - Issue long op rd=5, then decode rs1=5. Required: o_stall=1.
  - Apply LSU result rd=5, data=0xDEADBEEF. Required: pushed, and written the next cycle (wren=1, addr=5).
  - Required: stall drops the cycle after the write; regfile x5 reads 0xDEADBEEF.
- Priority:
  - Stimulus: FIFO holds rd=7/0x11; ALU rd=3/0x22 valid for 2 cycles.
  - Required: writes x3, then x3, then x7 (FIFO drained only when the ALU is idle).
- FIFO full:
  - Push 4 LSU results with the ALU continuously valid. Required: o_lsu_ready=0.
  - Present a 5th result and hold it. Required: it is accepted only after a pop.
  - Required: all 5 are written in push order.
- x0: LSU rd=0 and ALU rd=0. Required: never wren; issue long rd=0 sets no busy bit; rs1=0 never stalls.
- Reset mid-operation: with 3 entries queued and busy={5,6}, assert reset. Required: FIFO empty, busy=0, none of the queued writes appear after release.
